map_mem_multi: RTL and testbench

- Parametrised successor to the single-memory VME map: one VME-style slave port serving g_num_mem independent dual-port SRAMs.
- Each SRAM has a full read/write external port B.
- Provides configurable input/output pipelining, a read sequencer with write-priority collision handling, unmapped-address handling and port-A/port-B write-collision detection.
- Sits between the VME bridge and user logic needing several shared buffers.

---
 rtl/map_mem_multi_pkg.sv | 28 ++
 rtl/map_mem_multi_chan.sv | 110 +++++++++++
 rtl/map_mem_multi.sv | 223 ++++++++++++++++++++++
 tb/tb_map_mem_multi.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_mem_multi_pkg.sv
`default_nettype none
// ============================================================================
// map_mem_multi_pkg : shared read-FSM state type and sizing helpers
// Revision: 1.0
// ============================================================================
package map_mem_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } rd_state_t;

   // Holds any select value up to 7 plus headroom for the unmapped compare.
   localparam int SEL_BITS = 4;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/map_mem_multi_chan.sv
`default_nettype none
// ============================================================================
// map_mem_chan : one true dual-port SRAM channel with port-A select gating
//                and same-address A/B write collision flag
// Revision: 1.0
// ============================================================================
module cheby_dpssram #(
   parameter int g_data_width = 16,
   parameter int g_size       = 64,
   parameter int g_addr_width = 6
) (
   input  logic                    clk_i,
   input  logic [g_addr_width-1:0] a_adr_i,
   input  logic                    a_rd_i,
   input  logic                    a_we_i,
   input  logic [g_data_width-1:0] a_dat_i,
   output logic [g_data_width-1:0] a_dat_o,
   input  logic [g_addr_width-1:0] b_adr_i,
   input  logic                    b_rd_i,
   input  logic                    b_we_i,
   input  logic [g_data_width-1:0] b_dat_i,
   output logic [g_data_width-1:0] b_dat_o
);

   logic [g_data_width-1:0] mem_q [g_size];
   logic [g_data_width-1:0] a_dat_q;
   logic [g_data_width-1:0] b_dat_q;

   // Port A is write-first so a read merged with a same-word write sees new data.
   always_ff @(posedge clk_i) begin
      if (a_we_i) begin
         mem_q[a_adr_i] <= a_dat_i;
         a_dat_q        <= a_dat_i;
      end else if (a_rd_i) begin
         a_dat_q <= mem_q[a_adr_i];
      end
      if (b_we_i) begin
         mem_q[b_adr_i] <= b_dat_i;
      end
      if (b_rd_i) begin
         b_dat_q <= mem_q[b_adr_i];
      end
   end

   assign a_dat_o = a_dat_q;
   assign b_dat_o = b_dat_q;

endmodule

module map_mem_chan #(
   parameter int g_depth      = 64,
   parameter int g_data_width = 16,
   parameter int g_adr_w      = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    a_wsel_i,
   input  logic                    a_rsel_i,
   input  logic                    a_we_i,
   input  logic                    a_rd_i,
   input  logic [g_adr_w-1:0]      a_adr_i,
   input  logic [g_data_width-1:0] a_dat_i,
   output logic [g_data_width-1:0] a_dat_o,
   input  logic [g_adr_w-1:0]      b_adr_i,
   input  logic                    b_rd_i,
   input  logic                    b_wr_i,
   input  logic [g_data_width-1:0] b_dat_i,
   output logic [g_data_width-1:0] b_dat_o,
   output logic                    coll_o
);

   logic a_we;
   logic a_rd;
   logic coll_d;
   logic coll_q;

   assign a_we   = a_we_i & a_wsel_i;
   assign a_rd   = a_rd_i & a_rsel_i & ~a_we;
   assign coll_d = a_we & b_wr_i & (a_adr_i == b_adr_i);

   cheby_dpssram #(
      .g_data_width (g_data_width),
      .g_size       (g_depth),
      .g_addr_width (g_adr_w)
   ) u_ram (
      .clk_i   (clk_i),
      .a_adr_i (a_adr_i),
      .a_rd_i  (a_rd),
      .a_we_i  (a_we),
      .a_dat_i (a_dat_i),
      .a_dat_o (a_dat_o),
      .b_adr_i (b_adr_i),
      .b_rd_i  (b_rd_i),
      .b_we_i  (b_wr_i),
      .b_dat_i (b_dat_i),
      .b_dat_o (b_dat_o)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         coll_q <= 1'b0;
      end else begin
         coll_q <= coll_d;
      end
   end

   assign coll_o = coll_q;

endmodule
`default_nettype wire

// File: rtl/map_mem_multi.sv
`default_nettype none
// ============================================================================
// map_mem_multi : VME-style slave port mapped onto g_num_mem dual-port SRAMs
//                 with optional in/out pipelining and a read sequencer
// Revision: 1.0
// ============================================================================
module map_mem_multi
   import map_mem_multi_pkg::*;
#(
   parameter int g_num_mem    = 2,
   parameter int g_depth      = 64,
   parameter int g_data_width = 16,
   parameter int g_addr_width = 8,
   parameter int g_pipe_in    = 1,
   parameter int g_pipe_out   = 1
) (
   input  logic                                        Clk,
   input  logic                                        rst_n,
   input  logic [g_addr_width-1:0]                     VMEAddr,
   output logic [31:0]                                 VMERdData,
   input  logic [31:0]                                 VMEWrData,
   input  logic                                        VMERdMem,
   input  logic                                        VMEWrMem,
   output logic                                        VMERdDone,
   output logic                                        VMEWrDone,
   input  logic [g_num_mem*clog2(g_depth)-1:0]         m_adr_i,
   input  logic [g_num_mem-1:0]                        m_rd_i,
   input  logic [g_num_mem-1:0]                        m_wr_i,
   input  logic [g_num_mem*g_data_width-1:0]           m_dat_i,
   output logic [g_num_mem*g_data_width-1:0]           m_dat_o,
   output logic [g_num_mem-1:0]                        m_coll_o
);

   localparam int ADR_W = clog2(g_depth);
   localparam int SEL_W = clog2(g_num_mem);
   localparam int DW    = g_data_width;

   logic [ADR_W-1:0]    in_word;
   logic [SEL_BITS-1:0] in_sel;

   assign in_word = VMEAddr[ADR_W-1:0];

   generate
      if (SEL_W > 0) begin : g_sel
         assign in_sel = SEL_BITS'(VMEAddr[ADR_W+SEL_W-1:ADR_W]);
      end else begin : g_nosel
         assign in_sel = '0;
      end
      if (g_addr_width > ADR_W + SEL_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^VMEAddr[g_addr_width-1:ADR_W+SEL_W];
      end
      if (DW < 32) begin : g_wdat_hi
         logic unused_wdat_hi;
         assign unused_wdat_hi = ^VMEWrData[31:DW];
      end
   endgenerate

   // Write stage: what occupies port A this cycle, and whether a read must defer.
   logic                wr_act;
   logic [ADR_W-1:0]    wr_word;
   logic [SEL_BITS-1:0] wr_sel;
   logic [DW-1:0]       wr_dat;
   logic                wr_busy;

   generate
      if (g_pipe_in != 0) begin : g_pipe_in_reg
         logic                wr_q;
         logic [ADR_W-1:0]    wword_q;
         logic [SEL_BITS-1:0] wsel_q;
         logic [DW-1:0]       wdat_q;

         always_ff @(posedge Clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_q    <= 1'b0;
               wword_q <= '0;
               wsel_q  <= '0;
               wdat_q  <= '0;
            end else begin
               wr_q <= VMEWrMem;
               if (VMEWrMem) begin
                  wword_q <= in_word;
                  wsel_q  <= in_sel;
                  wdat_q  <= VMEWrData[DW-1:0];
               end
            end
         end

         assign wr_act  = wr_q;
         assign wr_word = wword_q;
         assign wr_sel  = wsel_q;
         assign wr_dat  = wdat_q;
         assign wr_busy = wr_q | VMEWrMem;
      end else begin : g_pipe_in_direct
         assign wr_act  = VMEWrMem;
         assign wr_word = in_word;
         assign wr_sel  = in_sel;
         assign wr_dat  = VMEWrData[DW-1:0];
         assign wr_busy = VMEWrMem;
      end
   endgenerate

   assign VMEWrDone = wr_act;

   rd_state_t           state_q, state_d;
   logic [ADR_W-1:0]    rword_q, rword_d;
   logic [SEL_BITS-1:0] rsel_q, rsel_d;
   logic [DW-1:0]       rdat_q, rdat_d;
   logic                rd_en;
   logic [ADR_W-1:0]    rd_word;
   logic [SEL_BITS-1:0] rd_sel;
   logic                rd_done;
   logic [DW-1:0]       rd_out;
   logic [DW-1:0]       ram_rdat;
   logic [DW-1:0]       a_q [g_num_mem];
   logic [ADR_W-1:0]    pa_word;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rword_q <= '0;
         rsel_q  <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         rword_q <= rword_d;
         rsel_q  <= rsel_d;
         rdat_q  <= rdat_d;
      end
   end

   // Unmapped selects match no channel and read back as zero.
   always_comb begin
      ram_rdat = '0;
      for (int k = 0; k < g_num_mem; k++) begin
         if (rsel_q == SEL_BITS'(k)) ram_rdat = a_q[k];
      end
   end

   always_comb begin
      state_d = state_q;
      rword_d = rword_q;
      rsel_d  = rsel_q;
      rdat_d  = rdat_q;
      rd_en   = 1'b0;
      rd_word = rword_q;
      rd_sel  = rsel_q;
      rd_done = 1'b0;
      rd_out  = rdat_q;
      unique case (state_q)
         ST_IDLE: begin
            if (VMERdMem) begin
               rword_d = in_word;
               rsel_d  = in_sel;
               if (wr_busy) begin
                  state_d = ST_ISSUE;
               end else begin
                  rd_en   = 1'b1;
                  rd_word = in_word;
                  rd_sel  = in_sel;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_ISSUE: begin
            // A write to the same word merges through the write-first port.
            if (!wr_act || (wr_sel == rsel_q && wr_word == rword_q)) begin
               rd_en   = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            rdat_d = ram_rdat;
            if (g_pipe_out != 0) begin
               state_d = ST_RESP;
            end else begin
               rd_out  = ram_rdat;
               rd_done = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            rd_done = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign VMERdData = 32'(rd_out);
   assign VMERdDone = rd_done;
   assign pa_word   = wr_act ? wr_word : rd_word;

   generate
      for (genvar k = 0; k < g_num_mem; k++) begin : g_chan
         map_mem_chan #(
            .g_depth      (g_depth),
            .g_data_width (DW),
            .g_adr_w      (ADR_W)
         ) u_chan (
            .clk_i    (Clk),
            .rst_n_i  (rst_n),
            .a_wsel_i (wr_sel == SEL_BITS'(k)),
            .a_rsel_i (rd_sel == SEL_BITS'(k)),
            .a_we_i   (wr_act),
            .a_rd_i   (rd_en),
            .a_adr_i  (pa_word),
            .a_dat_i  (wr_dat),
            .a_dat_o  (a_q[k]),
            .b_adr_i  (m_adr_i[k*ADR_W +: ADR_W]),
            .b_rd_i   (m_rd_i[k]),
            .b_wr_i   (m_wr_i[k]),
            .b_dat_i  (m_dat_i[k*DW +: DW]),
            .b_dat_o  (m_dat_o[k*DW +: DW]),
            .coll_o   (m_coll_o[k])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_map_mem_multi.sv
`default_nettype none
// ============================================================================
// tb_map_mem_multi : vector table plus read scoreboard for map_mem_multi
//                    built with three memories so selector 3 is unmapped
// Revision: 1.0
// ============================================================================
module tb_map_mem_multi;

   localparam int NM = 3;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int PW = 6;

   logic             Clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [AW-1:0]    VMEAddr = '0;
   logic [31:0]      VMERdData;
   logic [31:0]      VMEWrData = '0;
   logic             VMERdMem = 1'b0;
   logic             VMEWrMem = 1'b0;
   logic             VMERdDone;
   logic             VMEWrDone;
   logic [NM*PW-1:0] m_adr_i = '0;
   logic [NM-1:0]    m_rd_i = '0;
   logic [NM-1:0]    m_wr_i = '0;
   logic [NM*DW-1:0] m_dat_i = '0;
   logic [NM*DW-1:0] m_dat_o;
   logic [NM-1:0]    m_coll_o;

   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      int          lat;
   } vec_t;

   vec_t vecs [17];

   always #5 Clk = ~Clk;

   map_mem_multi #(
      .g_num_mem    (NM),
      .g_depth      (64),
      .g_data_width (DW),
      .g_addr_width (AW),
      .g_pipe_in    (1),
      .g_pipe_out   (1)
   ) dut (
      .Clk       (Clk),
      .rst_n     (rst_n),
      .VMEAddr   (VMEAddr),
      .VMERdData (VMERdData),
      .VMEWrData (VMEWrData),
      .VMERdMem  (VMERdMem),
      .VMEWrMem  (VMEWrMem),
      .VMERdDone (VMERdDone),
      .VMEWrDone (VMEWrDone),
      .m_adr_i   (m_adr_i),
      .m_rd_i    (m_rd_i),
      .m_wr_i    (m_wr_i),
      .m_dat_i   (m_dat_i),
      .m_dat_o   (m_dat_o),
      .m_coll_o  (m_coll_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard consumer: every read ack pops one expected word.
   always @(negedge Clk) begin : sb_mon
      logic [31:0] e;
      if (rst_n && VMERdDone) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rd_ack: got ack with data 0x%08h, expected no ack", VMERdData);
         end else begin
            e = exp_q.pop_front();
            check("rd_data", VMERdData, e);
         end
      end
   end

   // Starts just after a rising edge; returns just after a rising edge.
   task automatic access(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                         input int lat, input string name);
      int seen;
      seen      = -1;
      VMEAddr   = addr;
      VMEWrData = wr ? data : 32'hA5A5_A5A5;
      VMEWrMem  = wr;
      VMERdMem  = !wr;
      if (!wr) exp_q.push_back(data);
      @(negedge Clk);
      for (int i = 0; i < 10; i++) begin
         if ((wr ? VMEWrDone : VMERdDone) && seen < 0) seen = i;
         @(posedge Clk);
         #1;
         VMEWrMem = 1'b0;
         VMERdMem = 1'b0;
         if (seen >= 0) break;
         @(negedge Clk);
      end
      if (seen < 0) begin
         total++;
         bad++;
         $display("FAIL %s_lat: got no ack in 10 cycles, expected ack at %0d", name, lat);
         if (!wr) void'(exp_q.pop_back());
      end else begin
         check({name, "_lat"}, seen, lat);
      end
   endtask

   initial begin
      int wl;
      int rl;

      vecs[0]  = '{1'b1, 8'h05, 32'h0000_BEEF, 1};
      vecs[1]  = '{1'b0, 8'h05, 32'h0000_BEEF, 2};
      vecs[2]  = '{1'b1, 8'h45, 32'h0000_1234, 1};
      vecs[3]  = '{1'b0, 8'h05, 32'h0000_BEEF, 2};
      vecs[4]  = '{1'b0, 8'h45, 32'h0000_1234, 2};
      vecs[5]  = '{1'b1, 8'h00, 32'h0000_1111, 1};
      vecs[6]  = '{1'b1, 8'h80, 32'h0000_2222, 1};
      vecs[7]  = '{1'b1, 8'h40, 32'h0000_3333, 1};
      vecs[8]  = '{1'b1, 8'h3F, 32'hABCD_5A5A, 1};
      vecs[9]  = '{1'b1, 8'hBF, 32'h1234_5678, 1};
      vecs[10] = '{1'b0, 8'h3F, 32'h0000_5A5A, 2};
      vecs[11] = '{1'b0, 8'hBF, 32'h0000_5678, 2};
      vecs[12] = '{1'b1, 8'hC0, 32'h0000_DEAD, 1};
      vecs[13] = '{1'b0, 8'hC0, 32'h0000_0000, 2};
      vecs[14] = '{1'b0, 8'h00, 32'h0000_1111, 2};
      vecs[15] = '{1'b0, 8'h80, 32'h0000_2222, 2};
      vecs[16] = '{1'b0, 8'h40, 32'h0000_3333, 2};

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_rddata", VMERdData, 32'h0);
      check("rst_rddone", {31'b0, VMERdDone}, 32'h0);
      check("rst_wrdone", {31'b0, VMEWrDone}, 32'h0);
      check("rst_coll", {29'b0, m_coll_o}, 32'h0);
      @(posedge Clk);
      #1;
      rst_n = 1'b1;
      @(posedge Clk);
      #1;

      for (int v = 0; v < 17; v++) begin
         access(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].lat, $sformatf("vec%0d", v));
      end

      // Port B reads of mem0/mem1 word 5.
      m_adr_i = {6'd0, 6'd5, 6'd5};
      m_rd_i  = 3'b011;
      @(posedge Clk);
      #1;
      m_rd_i = '0;
      @(negedge Clk);
      check("pb_rd_ch1", {16'b0, m_dat_o[31:16]}, 32'h0000_1234);
      check("pb_rd_ch0", {16'b0, m_dat_o[15:0]}, 32'h0000_BEEF);

      // Port B write to mem2 word 10, seen from the VME side.
      @(posedge Clk);
      #1;
      m_adr_i = {6'd10, 6'd0, 6'd0};
      m_dat_i = {16'h7777, 16'h0, 16'h0};
      m_wr_i  = 3'b100;
      @(posedge Clk);
      #1;
      m_wr_i = '0;
      access(1'b0, 8'h8A, 32'h0000_7777, 2, "pb_wr_vme_rd");

      // Same-cycle write and read to one word: read deferred, returns new data.
      access(1'b1, 8'h07, 32'h0000_1111, 1, "pre_wr07");
      wl        = -1;
      rl        = -1;
      VMEAddr   = 8'h07;
      VMEWrData = 32'h0000_4242;
      VMEWrMem  = 1'b1;
      VMERdMem  = 1'b1;
      exp_q.push_back(32'h0000_4242);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (VMEWrDone && wl < 0) wl = i;
         if (VMERdDone && rl < 0) rl = i;
         @(posedge Clk);
         #1;
         VMEWrMem = 1'b0;
         VMERdMem = 1'b0;
      end
      check("simul_wr_lat", wl, 1);
      check("simul_rd_lat", rl, 3);
      access(1'b0, 8'h07, 32'h0000_4242, 2, "simul_reread");

      // Port A write to mem0 word 3 meets a port B write to the same word.
      VMEAddr   = 8'h03;
      VMEWrData = 32'h0000_1010;
      VMEWrMem  = 1'b1;
      @(negedge Clk);
      check("coll_t0", {29'b0, m_coll_o}, 32'h0);
      @(posedge Clk);
      #1;
      VMEWrMem = 1'b0;
      m_adr_i  = {6'd0, 6'd0, 6'd3};
      m_dat_i  = {16'h0, 16'h0, 16'h2020};
      m_wr_i   = 3'b001;
      @(negedge Clk);
      check("coll_t1", {29'b0, m_coll_o}, 32'h0);
      @(posedge Clk);
      #1;
      m_wr_i = '0;
      @(negedge Clk);
      check("coll_t2", {29'b0, m_coll_o}, 32'h0000_0001);
      @(posedge Clk);
      #1;
      @(negedge Clk);
      check("coll_t3", {29'b0, m_coll_o}, 32'h0);

      // Same word index on a different channel is not a collision.
      @(posedge Clk);
      #1;
      VMEAddr   = 8'h04;
      VMEWrData = 32'h0000_3030;
      VMEWrMem  = 1'b1;
      @(posedge Clk);
      #1;
      VMEWrMem = 1'b0;
      m_adr_i  = {6'd0, 6'd4, 6'd0};
      m_dat_i  = {16'h0, 16'h4040, 16'h0};
      m_wr_i   = 3'b010;
      @(posedge Clk);
      #1;
      m_wr_i = '0;
      @(negedge Clk);
      check("nocoll_xchan", {29'b0, m_coll_o}, 32'h0);
      @(posedge Clk);
      #1;
      access(1'b0, 8'h04, 32'h0000_3030, 2, "nocoll_rd_mem0");
      access(1'b0, 8'h44, 32'h0000_4040, 2, "nocoll_rd_mem1");

      // Reset while the read sequencer waits on RAM data.
      VMEAddr  = 8'h05;
      VMERdMem = 1'b1;
      @(posedge Clk);
      #1;
      VMERdMem = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("rstmid_rddone", {31'b0, VMERdDone}, 32'h0);
      check("rstmid_rddata", VMERdData, 32'h0);
      check("rstmid_coll", {29'b0, m_coll_o}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         check("rstmid_hold_done", {31'b0, VMERdDone}, 32'h0);
      end
      @(posedge Clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         check("rstrel_no_ack", {31'b0, VMERdDone}, 32'h0);
      end
      @(posedge Clk);
      #1;
      access(1'b0, 8'h05, 32'h0000_BEEF, 2, "post_rst_rd");

      repeat (3) @(posedge Clk);
      check("scoreboard_empty", exp_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
